irq_ctrl_apb: RTL and testbench
===============================

// Module: irq_ctrl_apb
// PURPOSE
//  Parametrised interrupt controller; next generation of the SoC's fixed 7-input intc.
//  Takes NUM_IRQ peripheral interrupts, level or rising-edge per source; a pulse source such as emaclite is set to edge.
//  Routes them to NUM_TGT CPU interrupt lines, each with its own enable mask and claim register.
//  Programmed over APB.
// PARAMETERS
//  NUM_IRQ   7   interrupt sources, 1..32
//  NUM_TGT   2   interrupt targets (irq_o bits), 1..4
//  ADDR_W    8   APB address width; only paddr[7:2] is decoded
// PORTS
//  clk_i      in   1          clock (soc_clk domain)
//  rst_i      in   1          synchronous reset, active-high
//  irq_i      in   NUM_IRQ    interrupt sources, active-high
//  irq_o      out  NUM_TGT    per-target interrupt request, registered
//  psel       in   1          APB select
//  penable    in   1          APB enable
//  pwrite     in   1          APB write
//  paddr      in   ADDR_W     APB byte address
//  pwdata     in   32         APB write data
//  prdata     out  32         APB read data, valid in access phase
//  pready     out  1          tied 1 (zero wait states)
//  pslverr    out  1          1 on access to an unmapped offset
// BEHAVIOUR
//  Reset: every register is 0, including MODE, PENDING, ENABLE_t, raw_q and raw_d; irq_o=0, prdata=0, pslverr=0.
//  Access: an access fires in a cycle with psel&penable. pready is always 1.
//  Register map (byte offsets):
//    0x00 RAW        RO   raw_q, the registered irq_i
//    0x04 MODE       RW   per bit: 1=rising edge, 0=level
//    0x08 PENDING    RO; W1C clears edge-mode bits only
//    0x10+4t ENABLE_t RW  source mask for target t
//    0x20+4t CLAIM_t RO   see claim rules below
//  Offsets not in the map: prdata=0, pslverr=1 in the access cycle, no state change.
//  Unused bits: bits >= NUM_IRQ read 0 and ignore writes.
//  Input sampling: raw_q <= irq_i every cycle; raw_d <= raw_q.
//  Pending rules:
//    level bit: pending = raw_q, recomputed every cycle.
//    edge bit: set when raw_q & ~raw_d; cleared by W1C or by a claim.
//    Set and clear of the same bit in one cycle: set wins.
//  MODE write: every bit whose mode changes has pending forced to 0 for one cycle.
//    No edge is detected in that cycle; normal evaluation resumes the next cycle.
//  Outputs: irq_o[t] <= |(pending & ENABLE_t).
//  Latency: irq_i rise at edge N -> raw_q at N+1 -> pending at N+2 -> irq_o at N+3.
//  Claim rules:
//    read value: lowest index i with pending[i] & ENABLE_t[i], returned as i+1; 0 if none.
//    edge-mode side effect: a read clears pending[i]. Level-mode reads have no side effect.
//    A claim is acted on only in the access cycle, once per APB transfer.
//  Simultaneous claims cannot occur: APB serialises accesses.
//  Reset mid-operation: all state returns to reset values on the next edge; an edge in flight is lost.
// CONFIGURATION
//  IRQ_CTRL_SYNC_EN defined:
//    adds a 2-flop synchroniser before raw_q, for asynchronous irq_i.
//    irq_i -> irq_o latency becomes 5 cycles.
//    reset value of the synchroniser flops is 0.
//  IRQ_CTRL_SYNC_EN undefined: no synchroniser; irq_i must be synchronous to clk_i; latency 3 cycles.
// TESTING
//  Reset, then read all offsets -> MODE/PENDING/ENABLE_0/CLAIM_0 read 0; irq_o=0.
//  Read offset 0x3C -> pslverr=1, prdata=0.
//  Level: MODE=0, ENABLE_0=0x1, irq_i[0]=1 at edge N -> irq_o[0]=1 at N+3.
//  Level (cont.): drop irq_i[0] -> irq_o[0]=0 three cycles later; CLAIM_0 reads 1 while asserted.
//  Edge: MODE=0x1, one-cycle pulse on irq_i[0], ENABLE_0=0x1 -> PENDING=0x1, irq_o[0]=1.
//  Edge (cont.): CLAIM_0 read returns 1 -> PENDING=0, irq_o[0]=0 next cycle.
//  Priority/routing: ENABLE_0=0x0C, ENABLE_1=0x10, irq_i[4:2] all high in level mode.
//    -> CLAIM_0=3, CLAIM_1=5, irq_o=2'b11.
//  Collision: W1C PENDING=0x1 in the same cycle a new edge arrives on source 0 -> PENDING[0] stays 1.
//  Mode switch: source 1 level-high, write MODE=0x2 -> PENDING[1]=0 and stays 0 while the input is held high.
//  Mode switch (cont.): a subsequent new rising edge sets PENDING[1].

Source files
------------

// File: rtl/irq_ctrl_apb.sv
// irq_ctrl_apb: NUM_IRQ-source / NUM_TGT-target interrupt controller, programmed over APB.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop synchroniser in front of raw_q for asynchronous irq_i.
module irq_ctrl_apb #(
  parameter int NUM_IRQ = 7,
  parameter int NUM_TGT = 2,
  parameter int ADDR_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_TGT-1:0] irq_o,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr
);
  typedef logic [NUM_IRQ-1:0] vec_t;

  vec_t               raw_q, raw_d, mode_q, pending_q, pending_d;
  vec_t               enable_q [NUM_TGT];
  logic [NUM_TGT-1:0] irq_q, irq_d;
  vec_t               irq_in;

`ifdef IRQ_CTRL_SYNC_EN
  vec_t sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_in = sync2_q;
`else
  assign irq_in = irq_i;
`endif

  logic        access, rd_fire, wr_fire;
  logic [5:0]  word;
  vec_t        wdata_v;

  assign access  = psel & penable;
  assign rd_fire = access & ~pwrite;
  assign wr_fire = access & pwrite;
  assign word    = paddr[7:2];
  assign wdata_v = pwdata[NUM_IRQ-1:0];
  assign pready  = 1'b1;

  logic               hit_map, is_claim, claim_fire, wr_mode, wr_pend;
  logic [NUM_TGT-1:0] wr_en;
  logic [31:0]        rdata, claim_id;
  vec_t               claim_hit, claim_1h;

  always_comb begin
    hit_map    = 1'b0;
    is_claim   = 1'b0;
    claim_fire = 1'b0;
    wr_mode    = 1'b0;
    wr_pend    = 1'b0;
    wr_en      = '0;
    rdata      = '0;
    claim_hit  = '0;
    case (word)
      6'h00: begin
        hit_map = 1'b1;
        rdata[NUM_IRQ-1:0] = raw_q;
      end
      6'h01: begin
        hit_map = 1'b1;
        rdata[NUM_IRQ-1:0] = mode_q;
        wr_mode = wr_fire;
      end
      6'h02: begin
        hit_map = 1'b1;
        rdata[NUM_IRQ-1:0] = pending_q;
        wr_pend = wr_fire;
      end
      default: ;
    endcase
    for (int t = 0; t < NUM_TGT; t++) begin
      if (word == 6'(4 + t)) begin
        hit_map = 1'b1;
        rdata[NUM_IRQ-1:0] = enable_q[t];
        wr_en[t] = wr_fire;
      end
      if (word == 6'(8 + t)) begin
        hit_map    = 1'b1;
        is_claim   = 1'b1;
        claim_hit  = pending_q & enable_q[t];
        claim_fire = rd_fire;
      end
    end
    // Scan high to low so the lowest pending index wins.
    claim_id = '0;
    claim_1h = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (claim_hit[i]) begin
        claim_id    = 32'(i + 1);
        claim_1h    = '0;
        claim_1h[i] = 1'b1;
      end
    end
    if (is_claim) rdata = claim_id;
  end

  assign prdata  = (rd_fire & hit_map) ? rdata : '0;
  assign pslverr = access & ~hit_map;

  vec_t edge_set, clr, mode_chg;

  always_comb begin
    edge_set = raw_q & ~raw_d;
    clr      = '0;
    if (wr_pend)    clr = clr | (wdata_v & mode_q);
    if (claim_fire) clr = clr | (claim_1h & mode_q);
    // Edge bits hold until cleared, with a fresh edge beating a same-cycle clear.
    pending_d = (mode_q & ((pending_q & ~clr) | edge_set)) | (~mode_q & raw_q);
    mode_chg  = wr_mode ? (mode_q ^ wdata_v) : '0;
    pending_d = pending_d & ~mode_chg;
    for (int t = 0; t < NUM_TGT; t++) begin
      irq_d[t] = |(pending_q & enable_q[t]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_q     <= '0;
      raw_d     <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      irq_q     <= '0;
      for (int t = 0; t < NUM_TGT; t++) enable_q[t] <= '0;
    end else begin
      raw_q     <= irq_in;
      raw_d     <= raw_q;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      if (wr_mode) mode_q <= wdata_v;
      for (int t = 0; t < NUM_TGT; t++) begin
        if (wr_en[t]) enable_q[t] <= wdata_v;
      end
    end
  end

  assign irq_o = irq_q;

  logic unused_ok;
  assign unused_ok = ^{paddr, pwdata};
endmodule

// File: tb/tb_irq_ctrl_apb.sv
// Scoreboard bench for irq_ctrl_apb: the driver queues hand-computed expectations,
// a negedge monitor pops and compares on every APB read access or irq_o probe.
module tb_irq_ctrl_apb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  irq_i = '0;
  logic [1:0]  irq_o;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        irq_probe = 1'b0;

  irq_ctrl_apb #(.NUM_IRQ(7), .NUM_TGT(2), .ADDR_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .irq_i(irq_i), .irq_o(irq_o),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        probe;
    logic [7:0]  addr;
    logic [31:0] rdata;
    logic        err;
    logic        chk_irq;
    logic [1:0]  irq;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always @(negedge clk) begin : monitor
    exp_t x;
    if ((psel && penable && !pwrite) || irq_probe) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: output event with no queued expectation (addr 0x%02h)", paddr);
      end else begin
        x = exp_q.pop_front();
        vectors++;
        if (x.probe) begin
          if (!irq_probe || irq_o !== x.irq) begin
            miscompares++;
            $display("FAIL vec %0d irq_o_probe: got irq_o=%b, expected %b", vectors, irq_o, x.irq);
          end
        end else if (irq_probe || paddr !== x.addr || prdata !== x.rdata || pslverr !== x.err ||
                     pready !== 1'b1 || (x.chk_irq && irq_o !== x.irq)) begin
          miscompares++;
          $display("FAIL vec %0d read_0x%02h: got prdata=%h pslverr=%b pready=%b irq_o=%b, expected prdata=%h pslverr=%b irq_o=%b (irq checked=%b)",
                   vectors, x.addr, prdata, pslverr, pready, irq_o, x.rdata, x.err, x.irq, x.chk_irq);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick(1);
    penable = 1'b1;
    tick(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_full(input logic [7:0] a, input logic [31:0] d, input logic e,
                         input logic ci, input logic [1:0] ei);
    exp_t x;
    x.probe = 1'b0; x.addr = a; x.rdata = d; x.err = e; x.chk_irq = ci; x.irq = ei;
    exp_q.push_back(x);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick(1);
    penable = 1'b1;
    tick(1);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] d, input logic e);
    rd_full(a, d, e, 1'b0, 2'b00);
  endtask

  task automatic rd_irq(input logic [7:0] a, input logic [31:0] d, input logic [1:0] ei);
    rd_full(a, d, 1'b0, 1'b1, ei);
  endtask

  task automatic probe(input logic [1:0] ei);
    exp_t x;
    x.probe = 1'b1; x.addr = '0; x.rdata = '0; x.err = 1'b0; x.chk_irq = 1'b1; x.irq = ei;
    exp_q.push_back(x);
    irq_probe = 1'b1;
    tick(1);
    irq_probe = 1'b0;
  endtask

  task automatic pulse0();
    irq_i[0] = 1'b1;
    tick(1);
    irq_i[0] = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rst = 1'b0;

    // Reset state and decode
    probe(2'b00);
    rd(8'h00, 32'h0, 1'b0);
    rd(8'h04, 32'h0, 1'b0);
    rd(8'h08, 32'h0, 1'b0);
    rd(8'h10, 32'h0, 1'b0);
    rd(8'h14, 32'h0, 1'b0);
    rd(8'h20, 32'h0, 1'b0);
    rd(8'h24, 32'h0, 1'b0);
    rd(8'h3C, 32'h0, 1'b1);
    rd(8'h0C, 32'h0, 1'b1);
    rd(8'h18, 32'h0, 1'b1);
    rd(8'h28, 32'h0, 1'b1);
    apb_wr(8'h3C, 32'hFFFF_FFFF);
    rd(8'h10, 32'h0, 1'b0);
    apb_wr(8'h10, 32'hFFFF_FFFF);
    rd(8'h10, 32'h7F, 1'b0);
    apb_wr(8'h10, 32'h1);
    rd(8'h10, 32'h1, 1'b0);

    // Level mode, exact 3-cycle latency on rise and fall
    irq_i[0] = 1'b1;
    tick(2);
    probe(2'b00);
    probe(2'b01);
    rd(8'h00, 32'h1, 1'b0);
    rd(8'h08, 32'h1, 1'b0);
    rd(8'h20, 32'h1, 1'b0);
    rd(8'h20, 32'h1, 1'b0);
    rd(8'h24, 32'h0, 1'b0);
    rd(8'h08, 32'h1, 1'b0);
    irq_i[0] = 1'b0;
    tick(2);
    probe(2'b01);
    probe(2'b00);
    rd(8'h08, 32'h0, 1'b0);
    rd(8'h20, 32'h0, 1'b0);

    // Edge mode and claim side effect
    apb_wr(8'h04, 32'h1);
    rd(8'h04, 32'h1, 1'b0);
    pulse0();
    tick(3);
    rd_irq(8'h08, 32'h1, 2'b01);
    rd(8'h00, 32'h0, 1'b0);
    rd(8'h20, 32'h1, 1'b0);
    rd_irq(8'h08, 32'h0, 2'b00);
    rd(8'h20, 32'h0, 1'b0);

    // W1C clears an edge bit
    pulse0();
    tick(3);
    rd(8'h08, 32'h1, 1'b0);
    apb_wr(8'h08, 32'h1);
    rd_irq(8'h08, 32'h0, 2'b00);

    // New edge in the same cycle as W1C: set wins
    pulse0();
    tick(3);
    rd(8'h08, 32'h1, 1'b0);
    fork
      apb_wr(8'h08, 32'h1);
      pulse0();
    join
    rd_irq(8'h08, 32'h1, 2'b01);
    rd(8'h20, 32'h1, 1'b0);
    rd(8'h08, 32'h0, 1'b0);

    // Priority and routing in level mode
    apb_wr(8'h04, 32'h0);
    apb_wr(8'h10, 32'h0C);
    apb_wr(8'h14, 32'h10);
    irq_i = 7'h1C;
    tick(4);
    rd_irq(8'h20, 32'h3, 2'b11);
    rd(8'h24, 32'h5, 1'b0);
    rd(8'h08, 32'h1C, 1'b0);
    apb_wr(8'h08, 32'h1C);
    rd(8'h08, 32'h1C, 1'b0);
    rd(8'h20, 32'h3, 1'b0);
    apb_wr(8'h10, 32'h08);
    rd(8'h20, 32'h4, 1'b0);

    // Mode switch level->edge with input held high
    irq_i = 7'h02;
    apb_wr(8'h10, 32'h02);
    tick(3);
    rd(8'h08, 32'h2, 1'b0);
    rd(8'h20, 32'h2, 1'b0);
    apb_wr(8'h04, 32'h2);
    rd(8'h08, 32'h0, 1'b0);
    tick(5);
    rd_irq(8'h08, 32'h0, 2'b00);
    irq_i = 7'h00;
    tick(2);
    irq_i = 7'h02;
    tick(4);
    rd_irq(8'h08, 32'h2, 2'b01);
    rd(8'h20, 32'h2, 1'b0);
    rd(8'h08, 32'h0, 1'b0);

    // Edge->level with input high: pending follows raw after the forced cycle
    apb_wr(8'h04, 32'h0);
    rd(8'h08, 32'h2, 1'b0);

    // Reset with an edge in flight
    apb_wr(8'h04, 32'h2);
    irq_i = 7'h00;
    tick(2);
    irq_i = 7'h02;
    tick(1);
    rst = 1'b1;
    irq_i = 7'h00;
    tick(1);
    rst = 1'b0;
    rd(8'h04, 32'h0, 1'b0);
    rd(8'h08, 32'h0, 1'b0);
    rd(8'h10, 32'h0, 1'b0);
    rd(8'h14, 32'h0, 1'b0);
    probe(2'b00);

    tick(3);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations: got %0d unconsumed, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
